me_core_arbiter: RTL and testbench
==================================

ME_CORE_ARBITER -- requirements
Module: me_core_arbiter

Interface
REQ-001 SHALL have parameter MB_ADDR_W, default 12, width of macroblock base address.
REQ-002 SHALL have parameter CNT_W, default 16, width of per-client completed-job counters.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0 / req1  input  1  client 0/1 four-phase job request.
REQ-006 SHALL have ports mb_addr0 / mb_addr1  input  MB_ADDR_W  client 0/1 macroblock base address, stable while reqN high.
REQ-007 SHALL have ports ack0 / ack1  output  1  client 0/1 four-phase acknowledge, result valid while high.
REQ-008 SHALL have port core_req  output  1  request to ME core.
REQ-009 SHALL have port core_ack  input  1  ME core acknowledge, four-phase.
REQ-010 SHALL have port core_mb_addr  output  MB_ADDR_W  address of granted job, held while core_req high.
REQ-011 SHALL have ports core_sad  input  16  and core_mvec  input  10  ME core result, valid while core_ack high.
REQ-012 SHALL have ports res_sad  output  16, res_mvec  output  10, res_id  output  1  latched result and owning client.
REQ-013 SHALL have ports done_cnt0 / done_cnt1  output  CNT_W  completed jobs per client.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, CAPTURE, CORE_FALL, CLIENT_ACK; all outputs registered.
REQ-015 IDLE: if (req0|req1) and core_ack==0, select winner, latch its mb_addr into core_mb_addr, go GRANT next edge; core_ack==1 in IDLE holds IDLE (stale ack ignored).
REQ-016 Round-robin: only one requester -> it wins; both -> client != last_grant wins; last_grant updated on IDLE->GRANT.
REQ-017 GRANT: core_req=1; on core_ack==1 go CAPTURE, latching core_sad/core_mvec into res_sad/res_mvec and winner into res_id on same edge.
REQ-018 CAPTURE: core_req=0 from this state onward; go CORE_FALL next edge unconditionally.
REQ-019 CORE_FALL: wait core_ack==0, then go CLIENT_ACK; increment winner's done_cnt on that edge, saturating at all-ones.
REQ-020 CLIENT_ACK: ackN=1 for winner only; when winner's reqN==0 go IDLE; ackN deasserts on entry to IDLE.
REQ-021 Winner dropping reqN before ack is a protocol violation: job SHALL still complete; ackN high exactly one cycle, then IDLE.
REQ-022 Non-winning client's request SHALL remain pending untouched; it SHALL be granted at the next IDLE evaluation.
REQ-023 Minimum latency: req edge sampled at cycle t -> core_req high t+1; core_ack at cycle u -> ackN high u+3 if core_ack falls at u+1.
REQ-024 res_sad/res_mvec/res_id SHALL hold until next CAPTURE; core_mb_addr SHALL hold until next IDLE->GRANT.
REQ-025 At most one of ack0, ack1 SHALL be high in any cycle; core_req SHALL be high only in GRANT.

Reset
REQ-026 rst_n==0 at a rising edge SHALL force IDLE, last_grant=1 (client 0 wins first tie), core_req=0, ack0=ack1=0, core_mb_addr=0, res_sad=16'hFFFF, res_mvec=0, res_id=0, done_cnt0=done_cnt1=0.
REQ-027 Reset mid-job SHALL abandon the job without result capture or count increment; after release, stale core_ack==1 SHALL block new grants until core_ack==0.

Verification
REQ-028 Single job: req0=1, mb_addr0=0x123; core model acks 40 cycles later with sad=0x0100, mvec=0x155 -> core_mb_addr=0x123, ack0=1, res_sad=0x0100, res_mvec=0x155, res_id=0, done_cnt0=1.
REQ-029 Tie: req0 and req1 raised same cycle after reset -> client 0 served first, client 1 next; repeat tie -> client 0 again (alternation holds over 4 rounds: 0,1,0,1).
REQ-030 Back-to-back single client: req1 only, 3 jobs -> all granted to client 1, done_cnt1=3, done_cnt0=0, never two acks high.
REQ-031 Early req drop: req0 falls during GRANT -> job completes, ack0 high exactly 1 cycle, done_cnt0 increments, FSM returns to IDLE.
REQ-032 Reset mid-GRANT with core_ack later held high 5 cycles: outputs at REQ-026 values, no grant until core_ack low, then normal operation.
REQ-033 Saturation: preload via 65536 jobs (or forced counter) at 0xFFFF -> further completion leaves done_cnt0=0xFFFF.

Source files
------------

// File: rtl/me_core_arbiter.sv
// Two-client round-robin arbiter in front of a single motion-estimation core.
// Four-phase handshakes on both sides; every output comes straight from a flop.
module me_core_arbiter #(
    parameter int MB_ADDR_W = 12,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [MB_ADDR_W-1:0] mb_addr0,
    input  logic [MB_ADDR_W-1:0] mb_addr1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 core_req,
    input  logic                 core_ack,
    output logic [MB_ADDR_W-1:0] core_mb_addr,
    input  logic [15:0]          core_sad,
    input  logic [9:0]           core_mvec,
    output logic [15:0]          res_sad,
    output logic [9:0]           res_mvec,
    output logic                 res_id,
    output logic [CNT_W-1:0]     done_cnt0,
    output logic [CNT_W-1:0]     done_cnt1
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        CAPTURE,
        CORE_FALL,
        CLIENT_ACK
    } state_t;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 winner_q, winner_d;
    logic [MB_ADDR_W-1:0] core_mb_addr_q, core_mb_addr_d;
    logic [15:0]          res_sad_q, res_sad_d;
    logic [9:0]           res_mvec_q, res_mvec_d;
    logic                 res_id_q, res_id_d;
    logic [CNT_W-1:0]     done_cnt0_q, done_cnt0_d;
    logic [CNT_W-1:0]     done_cnt1_q, done_cnt1_d;
    logic                 core_req_q, core_req_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 pick;
    logic                 win_req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // On a tie the client that was not granted last time wins.
    assign pick    = (req0 && req1) ? ~last_grant_q : req1;
    assign win_req = winner_q ? req1 : req0;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        winner_d       = winner_q;
        core_mb_addr_d = core_mb_addr_q;
        res_sad_d      = res_sad_q;
        res_mvec_d     = res_mvec_q;
        res_id_d       = res_id_q;
        done_cnt0_d    = done_cnt0_q;
        done_cnt1_d    = done_cnt1_q;

        case (state_q)
            IDLE: begin
                // A still-high core_ack is left over from an abandoned job.
                if ((req0 || req1) && !core_ack) begin
                    winner_d       = pick;
                    last_grant_d   = pick;
                    core_mb_addr_d = pick ? mb_addr1 : mb_addr0;
                    state_d        = GRANT;
                end
            end
            GRANT: begin
                if (core_ack) begin
                    res_sad_d  = core_sad;
                    res_mvec_d = core_mvec;
                    res_id_d   = winner_q;
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: state_d = CORE_FALL;
            CORE_FALL: begin
                if (!core_ack) begin
                    state_d = CLIENT_ACK;
                    if (winner_q) done_cnt1_d = sat_inc(done_cnt1_q);
                    else          done_cnt0_d = sat_inc(done_cnt0_q);
                end
            end
            CLIENT_ACK: begin
                if (!win_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        core_req_d = (state_d == GRANT);
        ack0_d     = (state_d == CLIENT_ACK) && !winner_d;
        ack1_d     = (state_d == CLIENT_ACK) &&  winner_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            winner_q       <= 1'b0;
            core_mb_addr_q <= '0;
            res_sad_q      <= 16'hFFFF;
            res_mvec_q     <= '0;
            res_id_q       <= 1'b0;
            done_cnt0_q    <= '0;
            done_cnt1_q    <= '0;
            core_req_q     <= 1'b0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            winner_q       <= winner_d;
            core_mb_addr_q <= core_mb_addr_d;
            res_sad_q      <= res_sad_d;
            res_mvec_q     <= res_mvec_d;
            res_id_q       <= res_id_d;
            done_cnt0_q    <= done_cnt0_d;
            done_cnt1_q    <= done_cnt1_d;
            core_req_q     <= core_req_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign core_req     = core_req_q;
    assign core_mb_addr = core_mb_addr_q;
    assign res_sad      = res_sad_q;
    assign res_mvec     = res_mvec_q;
    assign res_id       = res_id_q;
    assign done_cnt0    = done_cnt0_q;
    assign done_cnt1    = done_cnt1_q;

endmodule

// File: tb/tb_me_core_arbiter.sv
// Directed bench for me_core_arbiter; a second instance with 2-bit counters
// shares all inputs so counter saturation is reachable in a few jobs.
module tb_me_core_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [11:0] mb_addr0, mb_addr1;
    logic        ack0, ack1;
    logic        core_req;
    logic        core_ack;
    logic [11:0] core_mb_addr;
    logic [15:0] core_sad;
    logic [9:0]  core_mvec;
    logic [15:0] res_sad;
    logic [9:0]  res_mvec;
    logic        res_id;
    logic [15:0] done_cnt0, done_cnt1;

    logic        s_ack0, s_ack1, s_core_req, s_res_id;
    logic [11:0] s_core_mb_addr;
    logic [15:0] s_res_sad;
    logic [9:0]  s_res_mvec;
    logic [1:0]  s_done_cnt0, s_done_cnt1;

    int n_cmp = 0;
    int n_err = 0;
    int both_cnt = 0;

    me_core_arbiter #(.MB_ADDR_W(12), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .mb_addr0(mb_addr0), .mb_addr1(mb_addr1), .ack0(ack0), .ack1(ack1),
        .core_req(core_req), .core_ack(core_ack), .core_mb_addr(core_mb_addr),
        .core_sad(core_sad), .core_mvec(core_mvec), .res_sad(res_sad),
        .res_mvec(res_mvec), .res_id(res_id), .done_cnt0(done_cnt0),
        .done_cnt1(done_cnt1)
    );

    me_core_arbiter #(.MB_ADDR_W(12), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .mb_addr0(mb_addr0), .mb_addr1(mb_addr1), .ack0(s_ack0), .ack1(s_ack1),
        .core_req(s_core_req), .core_ack(core_ack), .core_mb_addr(s_core_mb_addr),
        .core_sad(core_sad), .core_mvec(core_mvec), .res_sad(s_res_sad),
        .res_mvec(s_res_mvec), .res_id(s_res_id), .done_cnt0(s_done_cnt0),
        .done_cnt1(s_done_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack0 === 1'b1 && ack1 === 1'b1) both_cnt++;
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; core_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Core model plus client-side completion for whichever client gets acked.
    task automatic serve_one(input logic [15:0] sad, input logic [9:0] mvec, input int dly,
                             output logic [11:0] addr_seen, output int who);
        int n;
        who = -1;
        addr_seen = 12'hFFF;
        n = 0;
        while (core_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) return;
        addr_seen = core_mb_addr;
        repeat (dly) @(negedge clk);
        core_sad = sad; core_mvec = mvec; core_ack = 1'b1;
        n = 0;
        while (core_req !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        core_ack = 1'b0;
        n = 0;
        while (ack0 !== 1'b1 && ack1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) return;
        who = (ack0 === 1'b1) ? 0 : 1;
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
        n = 0;
        while ((ack0 | ack1) !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (core_req !== 1'b0) begin n_err++; $display("FAIL reset_core_req: got %b want 0", core_req); end
        n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b want 00", {ack0, ack1}); end
        n_cmp++; if (core_mb_addr !== 12'h000) begin n_err++; $display("FAIL reset_addr: got %h want 000", core_mb_addr); end
        n_cmp++; if (res_sad !== 16'hFFFF) begin n_err++; $display("FAIL reset_sad: got %h want ffff", res_sad); end
        n_cmp++; if (res_mvec !== 10'h000 || res_id !== 1'b0) begin n_err++; $display("FAIL reset_res: got mvec=%h id=%b want 000/0", res_mvec, res_id); end
        n_cmp++; if (done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", done_cnt0, done_cnt1); end
    endtask

    task automatic test_single_job();
        logic [11:0] a;
        int who;
        mb_addr0 = 12'h123; req0 = 1'b1;
        serve_one(16'h0100, 10'h155, 40, a, who);
        n_cmp++; if (who !== 0) begin n_err++; $display("FAIL single_winner: got %0d want 0", who); end
        n_cmp++; if (a !== 12'h123) begin n_err++; $display("FAIL single_addr: got %h want 123", a); end
        n_cmp++; if (res_sad !== 16'h0100) begin n_err++; $display("FAIL single_sad: got %h want 0100", res_sad); end
        n_cmp++; if (res_mvec !== 10'h155) begin n_err++; $display("FAIL single_mvec: got %h want 155", res_mvec); end
        n_cmp++; if (res_id !== 1'b0) begin n_err++; $display("FAIL single_id: got %b want 0", res_id); end
        n_cmp++; if (done_cnt0 !== 16'd1 || done_cnt1 !== 16'd0) begin n_err++; $display("FAIL single_cnt: got %0d/%0d want 1/0", done_cnt0, done_cnt1); end
    endtask

    task automatic test_tie();
        logic [11:0] a;
        int who;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            mb_addr0 = 12'(12'h0A0 + r); mb_addr1 = 12'(12'h0B0 + r);
            req0 = 1'b1; req1 = 1'b1;
            serve_one(16'(16'h0010 + r), 10'h001, 2, a, who);
            n_cmp++; if (who !== 0 || a !== 12'(12'h0A0 + r)) begin n_err++; $display("FAIL tie_first r=%0d: got client %0d addr %h want 0 / %h", r, who, a, 12'(12'h0A0 + r)); end
            n_cmp++; if (res_id !== 1'b0) begin n_err++; $display("FAIL tie_first_id r=%0d: got %b want 0", r, res_id); end
            serve_one(16'(16'h0020 + r), 10'h002, 2, a, who);
            n_cmp++; if (who !== 1 || a !== 12'(12'h0B0 + r)) begin n_err++; $display("FAIL tie_second r=%0d: got client %0d addr %h want 1 / %h", r, who, a, 12'(12'h0B0 + r)); end
            n_cmp++; if (res_id !== 1'b1 || res_sad !== 16'(16'h0020 + r)) begin n_err++; $display("FAIL tie_second_res r=%0d: got id %b sad %h", r, res_id, res_sad); end
        end
        n_cmp++; if (done_cnt0 !== 16'd2 || done_cnt1 !== 16'd2) begin n_err++; $display("FAIL tie_cnt: got %0d/%0d want 2/2", done_cnt0, done_cnt1); end
    endtask

    task automatic test_latency();
        int n;
        logic saw_req;
        mb_addr1 = 12'h2F0; req1 = 1'b1;
        n = 0;
        while (core_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_cmp++; if (n !== 1) begin n_err++; $display("FAIL lat_grant: got %0d cycles want 1", n); end
        n_cmp++; if (core_mb_addr !== 12'h2F0) begin n_err++; $display("FAIL lat_addr: got %h want 2f0", core_mb_addr); end
        core_sad = 16'h0777; core_mvec = 10'h2AA; core_ack = 1'b1;
        @(negedge clk);
        saw_req = core_req;
        core_ack = 1'b0;
        n = 1;
        while (ack1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_cmp++; if (saw_req !== 1'b0) begin n_err++; $display("FAIL lat_req_drop: got %b want 0", saw_req); end
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL lat_ack: got %0d cycles want 3", n); end
        req1 = 1'b0;
        n = 0;
        while (ack1 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        n_cmp++; if (res_sad !== 16'h0777 || res_mvec !== 10'h2AA || res_id !== 1'b1) begin n_err++; $display("FAIL lat_res: got %h/%h/%b want 0777/2aa/1", res_sad, res_mvec, res_id); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a;
        int who;
        int b0;
        apply_reset();
        b0 = both_cnt;
        for (int j = 0; j < 3; j++) begin
            mb_addr1 = 12'(12'h300 + j); req1 = 1'b1;
            serve_one(16'(16'h0050 + j), 10'h00F, 1 + j, a, who);
            n_cmp++; if (who !== 1 || a !== 12'(12'h300 + j)) begin n_err++; $display("FAIL b2b_job j=%0d: got client %0d addr %h", j, who, a); end
        end
        n_cmp++; if (done_cnt1 !== 16'd3 || done_cnt0 !== 16'd0) begin n_err++; $display("FAIL b2b_cnt: got %0d/%0d want 0/3", done_cnt0, done_cnt1); end
        n_cmp++; if (both_cnt !== b0) begin n_err++; $display("FAIL b2b_two_acks: got %0d overlaps want 0", both_cnt - b0); end
    endtask

    task automatic test_early_drop();
        int n;
        int hi;
        mb_addr0 = 12'h055; req0 = 1'b1;
        n = 0;
        while (core_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        core_sad = 16'h0042; core_mvec = 10'h011; core_ack = 1'b1;
        n = 0;
        while (core_req !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        core_ack = 1'b0;
        hi = 0;
        repeat (10) begin @(negedge clk); if (ack0 === 1'b1) hi++; end
        n_cmp++; if (hi !== 1) begin n_err++; $display("FAIL early_ack_len: got %0d cycles want 1", hi); end
        n_cmp++; if (done_cnt0 !== 16'd1) begin n_err++; $display("FAIL early_cnt: got %0d want 1", done_cnt0); end
        n_cmp++; if (res_sad !== 16'h0042) begin n_err++; $display("FAIL early_sad: got %h want 0042", res_sad); end
    endtask

    task automatic test_saturation();
        logic [11:0] a;
        int who;
        for (int j = 0; j < 4; j++) begin
            mb_addr0 = 12'(12'h400 + j); req0 = 1'b1;
            serve_one(16'h0001, 10'h001, 1, a, who);
            if (j == 1) begin
                n_cmp++; if (s_done_cnt0 !== 2'd3) begin n_err++; $display("FAIL sat_reach: got %0d want 3", s_done_cnt0); end
            end
        end
        n_cmp++; if (done_cnt0 !== 16'd5) begin n_err++; $display("FAIL sat_wide_cnt: got %0d want 5", done_cnt0); end
        n_cmp++; if (s_done_cnt0 !== 2'd3) begin n_err++; $display("FAIL sat_hold: got %0d want 3", s_done_cnt0); end
        n_cmp++; if (s_done_cnt1 !== 2'd3) begin n_err++; $display("FAIL sat_cnt1: got %0d want 3", s_done_cnt1); end
    endtask

    task automatic test_reset_mid_grant();
        logic [11:0] a;
        int who;
        int n;
        int leaked;
        mb_addr0 = 12'h3C3; req0 = 1'b1;
        n = 0;
        while (core_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        rst_n = 1'b0; core_sad = 16'h1234; core_mvec = 10'h3FF; core_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (core_req !== 1'b0 || {ack0, ack1} !== 2'b00) begin n_err++; $display("FAIL rmid_ctrl: got req %b acks %b want 0/00", core_req, {ack0, ack1}); end
        n_cmp++; if (core_mb_addr !== 12'h000 || res_sad !== 16'hFFFF || res_mvec !== 10'h000 || res_id !== 1'b0) begin n_err++; $display("FAIL rmid_data: got %h %h %h %b", core_mb_addr, res_sad, res_mvec, res_id); end
        n_cmp++; if (done_cnt0 !== 16'd0 || done_cnt1 !== 16'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d/%0d want 0/0", done_cnt0, done_cnt1); end
        leaked = 0;
        repeat (4) begin @(negedge clk); if (core_req !== 1'b0) leaked++; end
        core_ack = 1'b0;
        n_cmp++; if (leaked !== 0) begin n_err++; $display("FAIL rmid_stale_ack: got %0d grant cycles want 0", leaked); end
        serve_one(16'h0200, 10'h0AB, 1, a, who);
        n_cmp++; if (who !== 0 || a !== 12'h3C3) begin n_err++; $display("FAIL rmid_resume: got client %0d addr %h want 0 / 3c3", who, a); end
        n_cmp++; if (res_sad !== 16'h0200 || done_cnt0 !== 16'd1) begin n_err++; $display("FAIL rmid_result: got sad %h cnt %0d want 0200 / 1", res_sad, done_cnt0); end
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        mb_addr0 = '0; mb_addr1 = '0;
        core_ack = 1'b0; core_sad = '0; core_mvec = '0;
        test_reset();
        test_single_job();
        test_tie();
        test_latency();
        test_back_to_back();
        test_early_drop();
        test_saturation();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
